// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory between the instruction cache (I port)
// and the data cache (D port). One transaction at a time, round-robin on ties,
// all outputs registered.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    // I port (instruction cache)
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    // D port (data cache)
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]        state_reg;
    logic              last_grant_reg;
    // A port is masked during its ready cycle: the cache registers the ready
    // pulse, so the request it shows at the next edge is the stale one that
    // just completed. Its next real request can be granted one edge later.
    logic              i_mask_reg;
    logic              d_mask_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              i_ready_reg;
    logic              d_ready_reg;

    logic              i_valid;
    logic              d_valid;
    logic              grant_i;
    logic              grant_d;

    // Request qualification and round-robin grant decision while idle
    always_comb begin
        i_valid = (i_mem_read | i_mem_write) & ~i_mask_reg;
        d_valid = (d_mem_read | d_mem_write) & ~d_mask_reg;
        grant_d = (state_reg == IDLE) && d_valid &&
                  (!i_valid || (last_grant_reg == GRANT_I));
        grant_i = (state_reg == IDLE) && i_valid && !grant_d;
    end

    // Control: state, last grant, masks, request strobes and ready pulses
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_I;
            i_mask_reg     <= 1'b0;
            d_mask_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            i_ready_reg    <= 1'b0;
            d_ready_reg    <= 1'b0;
        end else begin
            i_ready_reg <= 1'b0;
            d_ready_reg <= 1'b0;
            i_mask_reg  <= 1'b0;
            d_mask_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Write wins when a cache (illegally) raises both strobes
                    if (grant_d) begin
                        state_reg      <= BUSY_D;
                        last_grant_reg <= GRANT_D;
                        mem_write_reg  <= d_mem_write;
                        mem_read_reg   <= d_mem_read & ~d_mem_write;
                    end else if (grant_i) begin
                        state_reg      <= BUSY_I;
                        last_grant_reg <= GRANT_I;
                        mem_write_reg  <= i_mem_write;
                        mem_read_reg   <= i_mem_read & ~i_mem_write;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        state_reg     <= IDLE;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        i_ready_reg   <= 1'b1;
                        i_mask_reg    <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        state_reg     <= IDLE;
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        d_ready_reg   <= 1'b1;
                        d_mask_reg    <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Datapath: capture address/data on grant, return read data to the owner
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
        end else begin
            if (grant_d) begin
                mem_addr_reg  <= d_mem_addr;
                mem_wdata_reg <= d_mem_wdata;
            end else if (grant_i) begin
                mem_addr_reg  <= i_mem_addr;
                mem_wdata_reg <= i_mem_wdata;
            end
            // Completed writes leave the port's last read data untouched
            if ((state_reg == BUSY_I) && mem_ready && mem_read_reg) begin
                i_rdata_reg <= mem_rdata;
            end
            if ((state_reg == BUSY_D) && mem_ready && mem_read_reg) begin
                d_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign i_mem_rdata = i_rdata_reg;
    assign i_mem_ready = i_ready_reg;
    assign d_mem_rdata = d_rdata_reg;
    assign d_mem_ready = d_ready_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized cache
// traffic checked against a transaction-level model of two caches and a memory.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int NT = 14;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
    logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
    logic [DW-1:0] i_mem_wdata, d_mem_wdata, i_mem_rdata, d_mem_rdata;
    logic          i_mem_ready, d_mem_ready;
    logic          mem_read, mem_write, mem_ready;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // random-phase model state
    txn_t          tx [2][NT];
    int            hd [2];
    bit            stale [2];
    bit            presenting [2];
    int            gap [2];
    int            owner, lat, last_port, cyc, p_g, wait_n;
    bit            resp_sent, steady, act;
    txn_t          cur;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] last_rd [2];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic [AW-1:0] exp_order [4];
    logic [DW-1:0] rd_val;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
        d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        proc_reset = 1;
        clear_inputs();
        repeat (2) tick();
        proc_reset = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rdata"}, i_mem_rdata, 0);
        chk({tag, "_i_ready"}, i_mem_ready, 0);
        chk({tag, "_d_rdata"}, d_mem_rdata, 0);
        chk({tag, "_d_ready"}, d_mem_ready, 0);
    endtask

    // Step until the arbiter issues a memory request, bounded
    task automatic wait_grant(input string tag);
        wait_n = 0;
        while (!(mem_read | mem_write) && wait_n < 10) begin
            tick();
            wait_n++;
        end
        chk({tag, "_grant_seen"}, mem_read | mem_write, 1);
    endtask

    task automatic drive_port(input int p, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            i_mem_read = rd; i_mem_write = wr; i_mem_addr = a; i_mem_wdata = d;
        end else begin
            d_mem_read = rd; d_mem_write = wr; d_mem_addr = a; d_mem_wdata = d;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        proc_reset = 1;
        clear_inputs();
        repeat (2) tick();
        check_zero("reset");
        proc_reset = 0;

        // ---------------- single I read ----------------
        i_mem_read = 1; i_mem_addr = 28'h0000010;
        tick();
        chk("t1_mem_read", mem_read, 1);
        chk("t1_mem_write", mem_write, 0);
        chk("t1_mem_addr", mem_addr, 28'h0000010);
        repeat (3) tick();
        chk("t1_hold_read", mem_read, 1);
        mem_ready = 1; mem_rdata = {16{8'hA5}};
        tick();
        mem_ready = 0; mem_rdata = '0;
        chk("t1_i_ready", i_mem_ready, 1);
        chk("t1_i_rdata", i_mem_rdata, {16{8'hA5}});
        chk("t1_mem_read_drop", mem_read, 0);
        chk("t1_d_ready", d_mem_ready, 0);
        chk("t1_d_rdata", d_mem_rdata, 0);
        tick();
        chk("t1_ready_one_cycle", i_mem_ready, 0);
        chk("t1_stale_masked", mem_read, 0);
        i_mem_read = 0;
        tick();
        $display("t1 single I read done");

        // ---------------- simultaneous requests from reset ----------------
        do_reset();
        i_mem_read = 1; i_mem_addr = 28'h10;
        d_mem_write = 1; d_mem_addr = 28'h20; d_mem_wdata = 128'h1234;
        tick();
        chk("t2_d_first_write", mem_write, 1);
        chk("t2_d_first_read", mem_read, 0);
        chk("t2_d_addr", mem_addr, 28'h20);
        chk("t2_d_wdata", mem_wdata, 128'h1234);
        mem_ready = 1; mem_rdata = 128'hDEAD;
        tick();
        mem_ready = 0;
        chk("t2_d_ready", d_mem_ready, 1);
        chk("t2_d_rdata_kept", d_mem_rdata, 0);
        chk("t2_write_drop", mem_write, 0);
        chk("t2_i_ready_low", i_mem_ready, 0);
        tick();
        d_mem_write = 0;
        chk("t2_i_granted", mem_read, 1);
        chk("t2_i_addr", mem_addr, 28'h10);
        mem_ready = 1; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tick();
        mem_ready = 0;
        chk("t2_i_ready", i_mem_ready, 1);
        chk("t2_i_rdata", i_mem_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("t2_d_rdata_same", d_mem_rdata, 0);
        tick();
        i_mem_read = 0;
        chk("t2_idle", mem_read, 0);
        tick();
        $display("t2 simultaneous requests done");

        // ---------------- round-robin, continuous requests ----------------
        exp_order[0] = 28'h200; exp_order[1] = 28'h100;
        exp_order[2] = 28'h200; exp_order[3] = 28'h100;
        i_mem_read = 1; i_mem_addr = 28'h100;
        d_mem_read = 1; d_mem_addr = 28'h200;
        for (int k = 0; k < 4; k++) begin
            wait_grant("t3");
            chk("t3_order", mem_addr, exp_order[k]);
            rd_val = {32'hC0DE0000 + 32'(k), 96'h0};
            mem_ready = 1; mem_rdata = rd_val;
            tick();
            mem_ready = 0;
            if (exp_order[k] == 28'h200) begin
                chk("t3_d_ready", d_mem_ready, 1);
                chk("t3_d_rdata", d_mem_rdata, rd_val);
            end else begin
                chk("t3_i_ready", i_mem_ready, 1);
                chk("t3_i_rdata", i_mem_rdata, rd_val);
            end
            $display("t3 transaction %0d addr=%0h", k, exp_order[k]);
        end
        i_mem_read = 0; d_mem_read = 0;
        repeat (2) tick();

        // ---------------- D write-back then allocate ----------------
        d_mem_write = 1; d_mem_addr = 28'h30; d_mem_wdata = {4{32'h5A5A_0030}};
        wait_grant("t4");
        chk("t4_write", mem_write, 1);
        chk("t4_addr", mem_addr, 28'h30);
        chk("t4_wdata", mem_wdata, {4{32'h5A5A_0030}});
        mem_ready = 1;
        tick();
        mem_ready = 0;
        chk("t4_wb_ready", d_mem_ready, 1);
        tick();
        chk("t4_no_reissue_w", mem_write, 0);
        chk("t4_no_reissue_r", mem_read, 0);
        d_mem_write = 0; d_mem_read = 1; d_mem_addr = 28'h40;
        tick();
        chk("t4_alloc_read", mem_read, 1);
        chk("t4_alloc_write", mem_write, 0);
        chk("t4_alloc_addr", mem_addr, 28'h40);
        mem_ready = 1; mem_rdata = {4{32'h0000_4040}};
        tick();
        mem_ready = 0;
        chk("t4_alloc_ready", d_mem_ready, 1);
        chk("t4_alloc_rdata", d_mem_rdata, {4{32'h0000_4040}});
        d_mem_read = 0;
        repeat (2) tick();
        $display("t4 write-back then allocate done");

        // ---------------- stable hold and spurious ready ----------------
        i_mem_read = 1; i_mem_addr = 28'h50;
        wait_grant("t5");
        chk("t5_addr", mem_addr, 28'h50);
        i_mem_addr = 28'h999;
        repeat (2) tick();
        chk("t5_addr_held", mem_addr, 28'h50);
        chk("t5_read_held", mem_read, 1);
        mem_ready = 1; mem_rdata = {4{32'h5555_0050}};
        tick();
        mem_ready = 0;
        chk("t5_i_ready", i_mem_ready, 1);
        chk("t5_i_rdata", i_mem_rdata, {4{32'h5555_0050}});
        tick();
        chk("t5_stale_masked", mem_read, 0);
        i_mem_read = 0;
        tick();
        mem_ready = 1; mem_rdata = {4{32'hBAD0_BAD0}};
        tick();
        mem_ready = 0;
        chk("t5_spur_i_ready", i_mem_ready, 0);
        chk("t5_spur_d_ready", d_mem_ready, 0);
        chk("t5_spur_i_rdata", i_mem_rdata, {4{32'h5555_0050}});
        chk("t5_spur_d_rdata", d_mem_rdata, {4{32'h0000_4040}});
        chk("t5_spur_no_req", mem_read | mem_write, 0);
        tick();
        $display("t5 stable hold and spurious ready done");

        // ---------------- reset in the middle of BUSY_D ----------------
        d_mem_read = 1; d_mem_addr = 28'h60;
        wait_grant("t6");
        chk("t6_d_addr", mem_addr, 28'h60);
        i_mem_read = 1; i_mem_addr = 28'h70;
        tick();
        chk("t6_busy_hold", mem_addr, 28'h60);
        #2 proc_reset = 1;
        #1 check_zero("t6_async");
        tick();
        proc_reset = 0; d_mem_read = 0;
        tick();
        chk("t6_i_after_reset", mem_read, 1);
        chk("t6_i_addr", mem_addr, 28'h70);
        mem_ready = 1; mem_rdata = {4{32'h7070_7070}};
        tick();
        mem_ready = 0;
        chk("t6_i_ready", i_mem_ready, 1);
        chk("t6_i_rdata", i_mem_rdata, {4{32'h7070_7070}});
        chk("t6_d_rdata_cleared", d_mem_rdata, 0);
        tick();
        i_mem_read = 0;
        tick();
        $display("t6 reset mid-transaction done");

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NT; k++) begin
                tx[p][k].wr    = 1'($urandom_range(0, 1));
                tx[p][k].addr  = {1'(p), 23'd0, 4'($urandom_range(0, 15))};
                tx[p][k].wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            hd[p] = 0; stale[p] = 0; presenting[p] = 0; gap[p] = 0; last_rd[p] = '0;
        end
        owner = -1; resp_sent = 0; last_port = -1; steady = 0; lat = 0; cyc = 0;
        while ((hd[0] < NT || hd[1] < NT || owner >= 0) && cyc < 3000) begin
            tick();
            cyc++;
            act = mem_read | mem_write;
            if (owner >= 0 && resp_sent) begin
                chk("rnd_req_drop", act, 0);
                chk("rnd_ready_owner", (owner == 0) ? i_mem_ready : d_mem_ready, 1);
                chk("rnd_ready_other", (owner == 0) ? d_mem_ready : i_mem_ready, 0);
                if (cur.wr) mem_model[cur.addr] = cur.wdata;
                else last_rd[owner] = exp_rd;
                $display("rnd completion port=%0d wr=%0d addr=%0h", owner, cur.wr, cur.addr);
                hd[owner]++;
                stale[owner] = 1;
                steady = 1;
                owner = -1;
                resp_sent = 0;
            end else begin
                chk("rnd_i_ready_low", i_mem_ready, 0);
                chk("rnd_d_ready_low", d_mem_ready, 0);
                if (owner < 0 && act) begin
                    p_g = int'(mem_addr[AW-1]);
                    chk("rnd_grant_presented", presenting[p_g], 1);
                    chk("rnd_round_robin", (p_g == last_port) && steady, 0);
                    cur = tx[p_g][(hd[p_g] < NT) ? hd[p_g] : NT - 1];
                    chk("rnd_addr", mem_addr, cur.addr);
                    chk("rnd_kind_w", mem_write, cur.wr);
                    chk("rnd_kind_r", mem_read, !cur.wr);
                    if (cur.wr) chk("rnd_wdata", mem_wdata, cur.wdata);
                    owner = p_g;
                    last_port = p_g;
                    steady = 0;
                    lat = $urandom_range(0, 3);
                end else if (owner >= 0) begin
                    chk("rnd_busy_req", act, 1);
                    chk("rnd_busy_addr", mem_addr, cur.addr);
                end
            end
            chk("rnd_i_rdata", i_mem_rdata, last_rd[0]);
            chk("rnd_d_rdata", d_mem_rdata, last_rd[1]);

            // memory side for the next edge
            mem_ready = 0;
            mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (owner >= 0 && !resp_sent) begin
                if (lat == 0) begin
                    mem_ready = 1;
                    if (!cur.wr) begin
                        if (mem_model.exists(cur.addr)) exp_rd = mem_model[cur.addr];
                        else begin
                            exp_rd = {$urandom(), $urandom(), $urandom(), $urandom()};
                            mem_model[cur.addr] = exp_rd;
                        end
                        mem_rdata = exp_rd;
                    end
                    resp_sent = 1;
                end else begin
                    lat--;
                end
            end

            // cache side for the next edge
            for (int p = 0; p < 2; p++) begin
                if (stale[p]) begin
                    // the cache still shows the completed request for one more edge
                    stale[p] = 0;
                    presenting[p] = 0;
                    gap[p] = $urandom_range(0, 2);
                end else if (gap[p] > 0) begin
                    gap[p]--;
                    presenting[p] = 0;
                    drive_port(p, 0, 0, 28'($urandom()), '0);
                end else if (hd[p] < NT) begin
                    presenting[p] = 1;
                    drive_port(p, !tx[p][hd[p]].wr, tx[p][hd[p]].wr,
                               tx[p][hd[p]].addr, tx[p][hd[p]].wdata);
                end else begin
                    presenting[p] = 0;
                    drive_port(p, 0, 0, 28'($urandom()), '0);
                end
            end
            if (last_port >= 0 && !presenting[1 - last_port]) steady = 0;
        end
        chk("rnd_within_budget", cyc < 3000, 1);
        chk("rnd_i_drained", hd[0], NT);
        chk("rnd_d_drained", hd[1], NT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
